// File: rtl/compalu_pkg.sv
// Shared definitions for the CompALU front end: instruction word layout and
// the issue-unit state encoding.
package compalu_pkg;

  localparam int INSTR_W = 32;

  // R-type field positions: OpCode_Src1_Src2_RESERVED_shamt_funct
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int SRC1_MSB   = 25;
  localparam int SRC1_LSB   = 21;
  localparam int SRC2_MSB   = 20;
  localparam int SRC2_LSB   = 16;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/instr_mem.sv
// Single-port program RAM with synchronous write and registered synchronous read.
// The read register doubles as the issued-instruction output, so it is the only part reset.
module instr_mem
  import compalu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read data holds between reads so the last issued word stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Program feeder for the CompALU: loads a short instruction program and issues it
// word by word to the ALU over a valid/ready handshake.
module instr_issue_unit
  import compalu_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int INSTR_W = compalu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [AW:0]        prog_len,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc_out,
  output logic               busy,
  output logic               done
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  issue_state_t  state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [AW:0]   len, len_nxt;
  logic          valid_nxt, done_nxt;
  logic          mem_wr, mem_rd;
  logic [AW:0]   len_m1;
  logic          last_word;

  assign len_m1    = len - ONE_L;
  assign last_word = ({1'b0, pc} == len_m1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    len_nxt   = len;
    valid_nxt = instr_valid;
    done_nxt  = done;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    case (state)
      IDLE, DONE: begin
        mem_wr = load_en;
        if (abort) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
          pc_nxt    = '0;
        end else if (start) begin
          pc_nxt = '0;
          if (prog_len == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH;
            len_nxt   = clamp_len(prog_len);
            done_nxt  = 1'b0;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          done_nxt  = 1'b0;
          pc_nxt    = '0;
        end else begin
          mem_rd    = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Abort wins over a same-cycle handshake: that word is not issued.
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          done_nxt  = 1'b0;
          pc_nxt    = '0;
        end else if (instr_valid && instr_ready) begin
          valid_nxt = 1'b0;
          if (last_word) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      len         <= len_nxt;
      instr_valid <= valid_nxt;
      done        <= done_nxt;
    end
  end

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_wr | mem_rd),
    .we    (mem_wr),
    .addr  (mem_rd ? pc : load_addr),
    .wdata (load_data),
    .rdata (instr_out)
  );

  assign pc_out = pc;
  assign busy   = (state == FETCH) || (state == ISSUE);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: expected issued words are queued by the
// stimulus and checked by a monitor at each accepted handshake.
module tb_instr_issue_unit;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int W     = 32;

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          abort;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  int   acc_cyc[$];

  instr_issue_unit #(.DEPTH(DEPTH), .AW(AW), .INSTR_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .prog_len    (prog_len),
    .abort       (abort),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a word is issued when valid&&ready is seen mid-cycle without abort.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !abort) begin
      n_acc++;
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", instr_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_data", instr_out, e.data);
        check("issue_pc", 32'(pc_out), 32'(e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d, input int p);
    exp_t e;
    e.data = d;
    e.pc   = AW'(p);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int len);
    start    = 1'b1;
    prog_len = (AW+1)'(len);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_pc(input int target, input string name);
    int n = 0;
    while (pc_out !== AW'(target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({name, "_timeout"}, 32'(pc_out), 32'(target));
  endtask

  task automatic push_prog3();
    push(32'h00221020, 0);
    push(32'h00432022, 1);
    push(32'h00000000, 2);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; prog_len = '0; abort = 1'b0; instr_ready = 1'b1;
    #12;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: three-word program, ready high
    load(0, 32'h00221020);
    load(1, 32'h00432022);
    load(2, 32'h00000000);
    push_prog3();
    acc_cyc.delete();
    do_start(3);
    check("t1_lat1_valid", 32'(instr_valid), 32'd0);
    check("t1_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_lat2_valid", 32'(instr_valid), 32'd1);
    check("t1_lat2_instr", instr_out, 32'h00221020);
    wait_done("t1_done");
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_valid", 32'(instr_valid), 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_acc_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("t1_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      check("t1_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end
    check("t1_instr_hold", instr_out, 32'h00000000);

    // 2: backpressure on word 1
    push_prog3();
    do_start(3);
    wait_pc(1, "t2_pc1");
    instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_valid", 32'(instr_valid), 32'd1);
      check("t2_hold_instr", instr_out, 32'h00432022);
      check("t2_hold_pc", 32'(pc_out), 32'd1);
      tick();
    end
    instr_ready = 1'b1;
    wait_done("t2_done");
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: zero-length program
    do_start(0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_valid", 32'(instr_valid), 32'd0);
    end

    // 4: abort during issue of word 1 with ready high
    push(32'h00221020, 0);
    do_start(3);
    wait_pc(1, "t4_pc1");
    tick();
    check("t4_issue_w1", 32'(instr_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_pc", 32'(pc_out), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    push_prog3();
    do_start(3);
    wait_done("t4_rerun");
    check("t4_rerun_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: asynchronous reset while word 1 is waiting
    push(32'h00221020, 0);
    do_start(3);
    wait_pc(1, "t5_pc1");
    instr_ready = 1'b0;
    tick();
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(instr_valid), 32'd0);
    check("t5_instr", instr_out, 32'd0);
    check("t5_pc", 32'(pc_out), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    push_prog3();
    do_start(3);
    wait_done("t5_rerun");
    check("t5_rerun_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: full 32-word program, prog_len clamped, load/start ignored while busy
    for (int i = 0; i < DEPTH; i++) load(i, 32'hA5000000 | 32'(i));
    for (int i = 0; i < DEPTH; i++) push(32'hA5000000 | 32'(i), i);
    n_acc = 0;
    do_start(40);
    wait_pc(1, "t6_pc1");
    load_en   = 1'b1;
    load_addr = AW'(5);
    load_data = 32'hDEADBEEF;
    start     = 1'b1;
    prog_len  = (AW+1)'(3);
    wait_pc(10, "t6_pc10");
    check("t6_busy_held", 32'(busy), 32'd1);
    load_en = 1'b0;
    start   = 1'b0;
    wait_done("t6_done");
    check("t6_acc_count", 32'(n_acc), 32'd32);
    check("t6_last_pc", 32'(pc_out), 32'd31);
    check("t6_last_instr", instr_out, 32'hA500001F);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
